ram_port_arbiter: RTL

- Round-robin arbiter that shares one single-port synchronous RAM (1-cycle read latency, write-priority) between NUM_REQ requesters.
- Each requester issues read/write commands over a valid/ready handshake. Read data returns on a per-requester response strobe.
- Sits between client blocks (DMA, CPU-side port, test loader) and the RAM instance; the arbiter is the only driver of the RAM command pins.

---
 rtl/ram_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM
// between NUM_REQ requesters, with burst hold and a 2-stage read return.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*AW-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_wr_en,
  output logic                          ram_rd_en,
  output logic [AW-1:0]                 ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_data_in,
  input  logic [DATA_WIDTH-1:0]         ram_data_out
);

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic                  owner_vld_q, owner_vld_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IW-1:0]         id1_q, id1_d;
  logic [NUM_REQ-1:0]    rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic                  win_vld;
  logic                  hold;
  logic                  found;
  logic [IW-1:0]         win_idx;
  logic [NUM_REQ-1:0]    others;

  // Arbitration: burst hold first, otherwise search from the pointer
  always_comb begin
    others  = req_valid & ~(NUM_REQ'(1) << owner_q);
    hold    = owner_vld_q && req_valid[owner_q] &&
              ((cnt_q < CW'(MAX_BURST)) || (others == '0));
    win_vld = |req_valid;
    win_idx = owner_q;
    found   = hold;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        win_idx = IW'((int'(ptr_q) + k) % NUM_REQ);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    if (!win_vld) begin
      owner_vld_d = 1'b0;
      cnt_d       = '0;
    end else if (hold) begin
      if (cnt_q != CW'(MAX_BURST))
        cnt_d = cnt_q + 1'b1;
    end else begin
      ptr_d       = (win_idx == IW'(NUM_REQ - 1)) ?
                    '0 : win_idx + 1'b1;
      owner_d     = win_idx;
      owner_vld_d = 1'b1;
      cnt_d       = CW'(1);
    end
  end

  always_comb begin
    req_ready = win_vld ? (NUM_REQ'(1) << win_idx) : '0;
    wr_d      = win_vld && req_we[win_idx];
    rd_d      = win_vld && !req_we[win_idx];
    addr_d    = win_vld ? req_addr[win_idx*AW +: AW] : addr_q;
    wdata_d   = win_vld ? req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH]
                        : wdata_q;
    id1_d     = win_vld ? win_idx : id1_q;
    rsp_d     = rd_q ? (NUM_REQ'(1) << id1_q) : '0;
  end

  // Read data passes straight through while valid, else holds
  always_comb begin
    rsp_rdata = (|rsp_q) ? ram_data_out : hold_q;
    hold_d    = rsp_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      id1_q       <= '0;
      rsp_q       <= '0;
      hold_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      id1_q       <= id1_d;
      rsp_q       <= rsp_d;
      hold_q      <= hold_d;
    end
  end

  assign ram_wr_en   = wr_q;
  assign ram_rd_en   = rd_q;
  assign ram_addr    = addr_q;
  assign ram_data_in = wdata_q;
  assign rsp_valid   = rsp_q;

endmodule
